// File: rtl/smi_tx_assembler_pkg.sv
// Shared definitions for the SMI TX assembler.
//   asm_state_e : assembler FSM states
//   I_SYNC      : required byte[7:6] of the first (I) byte of a word
//   Q_SYNC      : required byte[7:6] of the third (Q) byte of a word
//   CNT_W       : width of the statistics counters
//   sat_inc     : saturating counter increment
package smi_tx_assembler_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHunt,
        StB0,
        StB1,
        StB2,
        StB3
    } asm_state_e;

    localparam logic [1:0] I_SYNC = 2'b10;
    localparam logic [1:0] Q_SYNC = 2'b01;
    localparam int unsigned CNT_W = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/smi_tx_assembler_strobe_sync.sv
// Two-flop synchroniser for the asynchronous SMI write strobe, address and
// data, followed by a registered rising-edge detector on the strobe.
//   i_clk, i_reset : system clock, synchronous active-high reset
//   i_swe          : raw SMI write strobe
//   i_a, i_data    : raw SMI address and data
//   o_byte_evt     : one-cycle pulse per synchronised strobe rising edge
//   o_addr, o_byte : address and data from the same synchronised stage
module smi_tx_assembler_strobe_sync (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_swe,
    input  logic [2:0] i_a,
    input  logic [7:0] i_data,
    output logic       o_byte_evt,
    output logic [2:0] o_addr,
    output logic [7:0] o_byte
);

    // swe_q[1] is the synchronised strobe, swe_q[2] its previous value
    logic [2:0]      swe_q, swe_d;
    logic [1:0][2:0] a_q, a_d;
    logic [1:0][7:0] data_q, data_d;
    logic            evt_q, evt_d;
    logic [2:0]      addr_q, addr_d;
    logic [7:0]      byte_q, byte_d;

    always_comb begin
        swe_d  = {swe_q[1:0], i_swe};
        a_d    = {a_q[0], i_a};
        data_d = {data_q[0], i_data};
        evt_d  = swe_q[1] & ~swe_q[2];
        addr_d = a_q[1];
        byte_d = data_q[1];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            swe_q  <= '0;
            a_q    <= '0;
            data_q <= '0;
            evt_q  <= 1'b0;
            addr_q <= '0;
            byte_q <= '0;
        end else begin
            swe_q  <= swe_d;
            a_q    <= a_d;
            data_q <= data_d;
            evt_q  <= evt_d;
            addr_q <= addr_d;
            byte_q <= byte_d;
        end
    end

    assign o_byte_evt = evt_q;
    assign o_addr     = addr_q;
    assign o_byte     = byte_q;

endmodule

// File: rtl/smi_tx_assembler.sv
// Packs bytes written by the host over SMI into 32-bit I/Q words
// {b0,b1,b2,b3} for the TX FIFO, enforcing I sync on b0 and Q sync on b2,
// and requests more data (DREQ) while the FIFO fill level is low.
//   i_sys_clk, i_reset        : system clock, synchronous active-high reset
//   i_trx_state_tx            : 1 = TX mode, 0 = idle and discard
//   i_smi_a/_swe_srw/_data_in : raw asynchronous SMI write interface
//   i_fifo_full, i_fifo_level : TX FIFO status
//   o_fifo_push, o_fifo_data  : one-cycle push strobe and assembled word
//   o_smi_dreq                : registered data request
//   o_overflow_cnt            : words dropped because the FIFO was full
//   o_sync_err_cnt            : sync failures
// Build option: define SMI_TX_ASM_STATS_EN to build the two counters;
// otherwise they read as zero.
module smi_tx_assembler
    import smi_tx_assembler_pkg::*;
#(
    parameter logic [2:0]  ADDR_TX        = 3'b000,
    parameter int unsigned DREQ_LOW_WATER = 500,
    parameter int unsigned LEVEL_W        = 10
) (
    input  logic               i_sys_clk,
    input  logic               i_reset,
    input  logic               i_trx_state_tx,
    input  logic [2:0]         i_smi_a,
    input  logic               i_smi_swe_srw,
    input  logic [7:0]         i_smi_data_in,
    input  logic               i_fifo_full,
    input  logic [LEVEL_W-1:0] i_fifo_level,
    output logic               o_fifo_push,
    output logic [31:0]        o_fifo_data,
    output logic               o_smi_dreq,
    output logic [CNT_W-1:0]   o_overflow_cnt,
    output logic [CNT_W-1:0]   o_sync_err_cnt
);

    logic       byte_evt_raw;
    logic [2:0] byte_addr;
    logic [7:0] byte_val;
    logic       evt;

    smi_tx_assembler_strobe_sync u_sync (
        .i_clk      (i_sys_clk),
        .i_reset    (i_reset),
        .i_swe      (i_smi_swe_srw),
        .i_a        (i_smi_a),
        .i_data     (i_smi_data_in),
        .o_byte_evt (byte_evt_raw),
        .o_addr     (byte_addr),
        .o_byte     (byte_val)
    );

    assign evt = byte_evt_raw & (byte_addr == ADDR_TX);

    asm_state_e  state_q, state_d;
    logic [7:0]  b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
    logic [31:0] fifo_data_q, fifo_data_d;
    logic        push_q, push_d;
    logic        dreq_q, dreq_d;
    logic        sync_inc, ovf_inc;

    always_comb begin
        state_d     = state_q;
        b0_d        = b0_q;
        b1_d        = b1_q;
        b2_d        = b2_q;
        fifo_data_d = fifo_data_q;
        push_d      = 1'b0;
        sync_inc    = 1'b0;
        ovf_inc     = 1'b0;
        dreq_d      = i_trx_state_tx & (32'(i_fifo_level) < DREQ_LOW_WATER);

        if (!i_trx_state_tx) begin
            // Leaving TX mode discards the partial word and any edge seen now
            state_d = StIdle;
            b0_d    = '0;
            b1_d    = '0;
            b2_d    = '0;
        end else begin
            unique case (state_q)
                StIdle: state_d = StHunt;
                StHunt, StB0: begin
                    if (evt) begin
                        if (byte_val[7:6] == I_SYNC) begin
                            b0_d    = byte_val;
                            state_d = StB1;
                        end else begin
                            sync_inc = 1'b1;
                            state_d  = StHunt;
                        end
                    end
                end
                StB1: begin
                    if (evt) begin
                        b1_d    = byte_val;
                        state_d = StB2;
                    end
                end
                StB2: begin
                    if (evt) begin
                        if (byte_val[7:6] == Q_SYNC) begin
                            b2_d    = byte_val;
                            state_d = StB3;
                        end else begin
                            sync_inc = 1'b1;
                            b0_d     = '0;
                            b1_d     = '0;
                            state_d  = StHunt;
                        end
                    end
                end
                StB3: begin
                    if (evt) begin
                        // A dropped word still advances, so word alignment holds
                        if (i_fifo_full) begin
                            ovf_inc = 1'b1;
                        end else begin
                            push_d      = 1'b1;
                            fifo_data_d = {b0_q, b1_q, b2_q, byte_val};
                        end
                        state_d = StB0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            state_q     <= StIdle;
            b0_q        <= '0;
            b1_q        <= '0;
            b2_q        <= '0;
            fifo_data_q <= '0;
            push_q      <= 1'b0;
            dreq_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            b0_q        <= b0_d;
            b1_q        <= b1_d;
            b2_q        <= b2_d;
            fifo_data_q <= fifo_data_d;
            push_q      <= push_d;
            dreq_q      <= dreq_d;
        end
    end

    assign o_fifo_push = push_q;
    assign o_fifo_data = fifo_data_q;
    assign o_smi_dreq  = dreq_q;

`ifdef SMI_TX_ASM_STATS_EN
    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic [CNT_W-1:0] sync_cnt_q, sync_cnt_d;

    always_comb begin
        ovf_cnt_d  = ovf_inc ? sat_inc(ovf_cnt_q) : ovf_cnt_q;
        sync_cnt_d = sync_inc ? sat_inc(sync_cnt_q) : sync_cnt_q;
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            ovf_cnt_q  <= '0;
            sync_cnt_q <= '0;
        end else begin
            ovf_cnt_q  <= ovf_cnt_d;
            sync_cnt_q <= sync_cnt_d;
        end
    end

    assign o_overflow_cnt = ovf_cnt_q;
    assign o_sync_err_cnt = sync_cnt_q;
`else
    logic unused_stats;
    assign unused_stats   = sync_inc ^ ovf_inc;
    assign o_overflow_cnt = '0;
    assign o_sync_err_cnt = '0;
`endif

endmodule

// File: tb/tb_smi_tx_assembler.sv
// Self-checking bench for smi_tx_assembler: directed scenarios plus a
// randomized byte stream, all checked against a word-position model.
module tb_smi_tx_assembler;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx;
    logic [2:0]  smi_a;
    logic        swe;
    logic [7:0]  smi_d;
    logic        full;
    logic [9:0]  level;
    logic        push;
    logic [31:0] fdata;
    logic        dreq;
    logic [15:0] ovf_cnt;
    logic [15:0] sync_cnt;

    smi_tx_assembler dut (
        .i_sys_clk      (clk),
        .i_reset        (rst),
        .i_trx_state_tx (tx),
        .i_smi_a        (smi_a),
        .i_smi_swe_srw  (swe),
        .i_smi_data_in  (smi_d),
        .i_fifo_full    (full),
        .i_fifo_level   (level),
        .o_fifo_push    (push),
        .o_fifo_data    (fdata),
        .o_smi_dreq     (dreq),
        .o_overflow_cnt (ovf_cnt),
        .o_sync_err_cnt (sync_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_rise = 0;
    int got_cyc = 0;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && push) begin
            got_q.push_back(fdata);
            got_cyc = cyc;
        end
    end

    // Reference model: position inside the current word (0 = waiting for I byte)
    int         m_pos;
    logic [7:0] m_b[3];
    int         m_sync;
    int         m_ovf;

    function automatic logic [15:0] exp_cnt(input int v);
`ifdef SMI_TX_ASM_STATS_EN
        return (v > 65535) ? 16'hFFFF : 16'(v);
`else
        return (v > 0) ? 16'h0000 : 16'h0000;
`endif
    endfunction

    task automatic model_byte(input logic [2:0] a, input logic [7:0] d, input logic f);
        if (!tx || a != 3'b000) return;
        if (m_pos == 0) begin
            if (d[7:6] == 2'b10) begin m_b[0] = d; m_pos = 1; end
            else m_sync++;
        end else if (m_pos == 1) begin
            m_b[1] = d; m_pos = 2;
        end else if (m_pos == 2) begin
            if (d[7:6] == 2'b01) begin m_b[2] = d; m_pos = 3; end
            else begin m_sync++; m_pos = 0; end
        end else begin
            if (f) m_ovf++;
            else exp_q.push_back({m_b[0], m_b[1], m_b[2], d});
            m_pos = 0;
        end
    endtask

    task automatic write_byte(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        smi_a = a;
        smi_d = d;
        swe = 1'b1;
        last_rise = cyc;
        model_byte(a, d, full);
        repeat (2) @(negedge clk);
        swe = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic write_word(input logic [31:0] w);
        logic [31:0] t;
        t = w;
        for (int i = 3; i >= 0; i--) write_byte(3'b000, t[i*8 +: 8]);
    endtask

    task automatic drain();
        repeat (8) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        swe = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_pos = 0;
        m_sync = 0;
        m_ovf = 0;
        got_q.delete();
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; tx = 1'b0; smi_a = '0; swe = 1'b0; smi_d = '0;
        full = 1'b0; level = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (push !== 1'b0) begin n_fail++; $display("FAIL reset_push: got %b required 0", push); end
        n_cmp++; if (fdata !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h required 0", fdata); end
        n_cmp++; if (dreq !== 1'b0) begin n_fail++; $display("FAIL reset_dreq: got %b required 0", dreq); end
        n_cmp++; if (ovf_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_ovf: got %h required 0", ovf_cnt); end
        n_cmp++; if (sync_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_sync: got %h required 0", sync_cnt); end
        tx = 1'b1;
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        write_word(32'h8A124567);
        drain();
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL basic_count: got %0d required %0d", got_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_word: got %h required %h", got_q[i], exp_q[i]); end
        end
        n_cmp++; if (got_cyc - last_rise != 4) begin n_fail++; $display("FAIL basic_latency: got %0d required 4", got_cyc - last_rise); end
        n_cmp++; if (dreq !== 1'b1) begin n_fail++; $display("FAIL basic_dreq: got %b required 1", dreq); end
    endtask

    task automatic test_hunt();
        logic [7:0] seq[6] = '{8'h00, 8'h3F, 8'h8A, 8'h12, 8'h45, 8'h67};
        do_reset();
        foreach (seq[i]) write_byte(3'b000, seq[i]);
        drain();
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL hunt_count: got %0d required %0d", got_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL hunt_word: got %h required %h", got_q[i], exp_q[i]); end
        end
        n_cmp++; if (sync_cnt !== exp_cnt(m_sync)) begin n_fail++; $display("FAIL hunt_sync_cnt: got %0d required %0d", sync_cnt, exp_cnt(m_sync)); end
    endtask

    task automatic test_bad_q();
        logic [7:0] seq[7] = '{8'h80, 8'h00, 8'hC0, 8'h80, 8'h00, 8'h40, 8'h00};
        do_reset();
        foreach (seq[i]) write_byte(3'b000, seq[i]);
        drain();
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL badq_count: got %0d required %0d", got_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL badq_word: got %h required %h", got_q[i], exp_q[i]); end
        end
        n_cmp++; if (sync_cnt !== exp_cnt(m_sync)) begin n_fail++; $display("FAIL badq_sync_cnt: got %0d required %0d", sync_cnt, exp_cnt(m_sync)); end
    endtask

    task automatic test_overflow();
        do_reset();
        full = 1'b1;
        write_word(32'h80004000);
        write_word(32'h81014101);
        drain();
        n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL ovf_no_push: got %0d required 0", got_q.size()); end
        n_cmp++; if (ovf_cnt !== exp_cnt(m_ovf)) begin n_fail++; $display("FAIL ovf_cnt: got %0d required %0d", ovf_cnt, exp_cnt(m_ovf)); end
        full = 1'b0;
        write_word(32'h82024202);
        drain();
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL ovf_count: got %0d required %0d", got_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_word: got %h required %h", got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_mode_drop();
        do_reset();
        write_byte(3'b000, 8'h80);
        write_byte(3'b000, 8'h00);
        drain();
        @(negedge clk);
        tx = 1'b0;
        m_pos = 0;
        repeat (3) @(negedge clk);
        tx = 1'b1;
        repeat (2) @(negedge clk);
        write_word(32'h81014102);
        for (int i = 0; i < 4; i++) write_byte(3'b001, (i == 0) ? 8'h80 : (i == 2) ? 8'h40 : 8'h00);
        drain();
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL mode_count: got %0d required %0d", got_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL mode_word: got %h required %h", got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_word();
        do_reset();
        write_byte(3'b000, 8'h00);
        write_byte(3'b000, 8'h80);
        write_byte(3'b000, 8'h11);
        drain();
        do_reset();
        n_cmp++; if (sync_cnt !== 16'h0) begin n_fail++; $display("FAIL midrst_sync_cnt: got %0d required 0", sync_cnt); end
        write_byte(3'b000, 8'h45);
        write_byte(3'b000, 8'h67);
        write_word(32'h8A124567);
        drain();
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL midrst_count: got %0d required %0d", got_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL midrst_word: got %h required %h", got_q[i], exp_q[i]); end
        end
        n_cmp++; if (sync_cnt !== exp_cnt(m_sync)) begin n_fail++; $display("FAIL midrst_sync_after: got %0d required %0d", sync_cnt, exp_cnt(m_sync)); end
    endtask

    task automatic test_dreq();
        logic [9:0] lv[3] = '{10'd499, 10'd500, 10'd501};
        logic       ex[3] = '{1'b1, 1'b0, 1'b0};
        do_reset();
        foreach (lv[i]) begin
            @(negedge clk);
            level = lv[i];
            @(negedge clk);
            n_cmp++;
            if (dreq !== ex[i]) begin n_fail++; $display("FAIL dreq_level_%0d: got %b required %b", lv[i], dreq, ex[i]); end
        end
        // registered: a drop from 499 to 500 shows up one edge later
        @(negedge clk); level = 10'd499;
        @(negedge clk); level = 10'd500;
        n_cmp++; if (dreq !== 1'b1) begin n_fail++; $display("FAIL dreq_lag: got %b required 1", dreq); end
        @(negedge clk);
        n_cmp++; if (dreq !== 1'b0) begin n_fail++; $display("FAIL dreq_after_lag: got %b required 0", dreq); end
        level = 10'd0;
        tx = 1'b0;
        @(negedge clk);
        n_cmp++; if (dreq !== 1'b0) begin n_fail++; $display("FAIL dreq_tx_off: got %b required 0", dreq); end
        tx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic [2:0] a;
        do_reset();
        for (int n = 0; n < 80; n++) begin
            d = 8'($urandom);
            if ($urandom_range(3) != 0) begin
                if (m_pos == 0) d[7:6] = 2'b10;
                else if (m_pos == 2) d[7:6] = 2'b01;
            end
            a = ($urandom_range(7) == 0) ? 3'($urandom_range(7, 1)) : 3'b000;
            full = ($urandom_range(5) == 0);
            write_byte(a, d);
        end
        full = 1'b0;
        drain();
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL rand_count: got %0d required %0d", got_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_word_%0d: got %h required %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (sync_cnt !== exp_cnt(m_sync)) begin n_fail++; $display("FAIL rand_sync_cnt: got %0d required %0d", sync_cnt, exp_cnt(m_sync)); end
        n_cmp++; if (ovf_cnt !== exp_cnt(m_ovf)) begin n_fail++; $display("FAIL rand_ovf_cnt: got %0d required %0d", ovf_cnt, exp_cnt(m_ovf)); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hunt();
        test_bad_q();
        test_overflow();
        test_mode_drop();
        test_reset_mid_word();
        test_dreq();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
